uart_decimal_parser: RTL and testbench



---
 rtl/uart_decimal_parser.sv | 150 +++++++++++++++
 tb/tb_uart_decimal_parser.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_decimal_parser.sv
// ASCII decimal line parser: accumulates '0'-'9' digits and publishes the value on CR/LF.
// Optional inter-byte timeout in ACCUM is enabled by defining DEC_PARSER_TIMEOUT_EN.
module uart_decimal_parser #(
  parameter int DATA_W      = 25,
  parameter int MAX_DIGITS  = 7,
  parameter int TIMEOUT_CYC = 2700000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] dec_value,
  output logic              dec_valid,
  output logic              dec_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    ERROR
  } state_t;

  if (DATA_W < 4 || MAX_DIGITS < 1 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("uart_decimal_parser: unsupported parameter set");
  end

  state_t            state, state_n;
  logic [DATA_W-1:0] acc, acc_n, value_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              valid_n, err_n;
  logic              is_digit, is_term, is_space;
  logic [DATA_W+3:0] acc_x, next_acc;
  logic              overflow;

`ifdef DEC_PARSER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  logic [TMR_W-1:0] tmr, tmr_n;
`endif

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
  assign is_space = (rx_data == 8'h20);

  // acc*10 + d with 4 guard bits so an overflow past DATA_W is visible
  assign acc_x    = {4'b0000, acc};
  assign next_acc = (acc_x << 3) + (acc_x << 1) + {{DATA_W{1'b0}}, rx_data[3:0]};
  assign overflow = |next_acc[DATA_W+3:DATA_W];

  assign busy = (state == ACCUM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      dec_value <= '0;
      dec_valid <= 1'b0;
      dec_err   <= 1'b0;
`ifdef DEC_PARSER_TIMEOUT_EN
      tmr       <= '0;
`endif
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      dec_value <= value_n;
      dec_valid <= valid_n;
      dec_err   <= err_n;
`ifdef DEC_PARSER_TIMEOUT_EN
      tmr       <= tmr_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    value_n = dec_value;
    valid_n = 1'b0;
    err_n   = 1'b0;
`ifdef DEC_PARSER_TIMEOUT_EN
    tmr_n   = tmr;
`endif

    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (is_digit) begin
            acc_n   = {{(DATA_W-4){1'b0}}, rx_data[3:0]};
            cnt_n   = CNT_W'(1);
            state_n = ACCUM;
          end else if (!is_term && !is_space) begin
            err_n   = 1'b1;
            state_n = ERROR;
          end
        end
      end

      ACCUM: begin
        if (rx_valid) begin
          if (is_digit) begin
            if (cnt == CNT_W'(MAX_DIGITS) || overflow) begin
              err_n   = 1'b1;
              state_n = ERROR;
            end else begin
              acc_n = next_acc[DATA_W-1:0];
              cnt_n = cnt + CNT_W'(1);
            end
          end else if (is_term) begin
            value_n = acc;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = ERROR;
          end
        end
`ifdef DEC_PARSER_TIMEOUT_EN
        else if (tmr == TMR_LAST) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          tmr_n = tmr + TMR_W'(1);
        end
`endif
      end

      ERROR: begin
        if (rx_valid && is_term) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase

    // Partial number only lives in ACCUM
    if (state_n != ACCUM) begin
      acc_n = '0;
      cnt_n = '0;
    end
`ifdef DEC_PARSER_TIMEOUT_EN
    if (state_n != ACCUM || rx_valid) tmr_n = '0;
`endif
  end

endmodule

// File: tb/tb_uart_decimal_parser.sv
// Scoreboard bench for uart_decimal_parser: default-width instance (a) and DATA_W=8/MAX_DIGITS=3 instance (b).
// Expectations for DEC_PARSER_TIMEOUT_EN follow the same macro.
module tb_uart_decimal_parser;

  localparam int EV_NONE  = 0;
  localparam int EV_VALID = 1;
  localparam int EV_ERR   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data_a = 8'h00, rx_data_b = 8'h00;
  logic        rx_valid_a = 1'b0, rx_valid_b = 1'b0;
  logic [24:0] dec_value_a;
  logic [7:0]  dec_value_b;
  logic        dec_valid_a, dec_err_a, busy_a;
  logic        dec_valid_b, dec_err_b, busy_b;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          is_err;
    logic [24:0] value;
    int          due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  uart_decimal_parser #(.DATA_W(25), .MAX_DIGITS(7), .TIMEOUT_CYC(100)) dut_a (
    .clk(clk), .rst(rst), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .dec_value(dec_value_a), .dec_valid(dec_valid_a), .dec_err(dec_err_a), .busy(busy_a)
  );

  uart_decimal_parser #(.DATA_W(8), .MAX_DIGITS(3), .TIMEOUT_CYC(100)) dut_b (
    .clk(clk), .rst(rst), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .dec_value(dec_value_b), .dec_valid(dec_valid_b), .dec_err(dec_err_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for instance a: every pulse must match the oldest expectation in kind, cycle and value
  always @(negedge clk) begin
    if (dec_valid_a && dec_err_a) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL a_exclusive: dec_valid=1 dec_err=1 at cycle %0d, required at most one", cyc);
    end
    if (dec_valid_a || dec_err_a) begin
      n_checks++;
      if (qa.size() == 0) begin
        n_errors++;
        $display("[TB] FAIL a_unexpected: pulse valid=%0b err=%0b at cycle %0d, required none", dec_valid_a, dec_err_a, cyc);
      end else if (qa[0].due > cyc) begin
        n_errors++;
        $display("[TB] FAIL a_early: pulse at cycle %0d, required at cycle %0d", cyc, qa[0].due);
      end else if (qa[0].due == cyc) begin
        if (dec_err_a !== qa[0].is_err) begin
          n_errors++;
          $display("[TB] FAIL a_kind: err=%0b at cycle %0d, required err=%0b", dec_err_a, cyc, qa[0].is_err);
        end else if (!qa[0].is_err && dec_value_a !== qa[0].value) begin
          n_errors++;
          $display("[TB] FAIL a_value: dec_value=%0d, required %0d", dec_value_a, qa[0].value);
        end
        void'(qa.pop_front());
      end
    end
    while (qa.size() > 0 && qa[0].due < cyc) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL a_missing: no pulse err=%0b at cycle %0d", qa[0].is_err, qa[0].due);
      void'(qa.pop_front());
    end
  end

  always @(negedge clk) begin
    if (dec_valid_b && dec_err_b) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL b_exclusive: dec_valid=1 dec_err=1 at cycle %0d, required at most one", cyc);
    end
    if (dec_valid_b || dec_err_b) begin
      n_checks++;
      if (qb.size() == 0) begin
        n_errors++;
        $display("[TB] FAIL b_unexpected: pulse valid=%0b err=%0b at cycle %0d, required none", dec_valid_b, dec_err_b, cyc);
      end else if (qb[0].due > cyc) begin
        n_errors++;
        $display("[TB] FAIL b_early: pulse at cycle %0d, required at cycle %0d", cyc, qb[0].due);
      end else if (qb[0].due == cyc) begin
        if (dec_err_b !== qb[0].is_err) begin
          n_errors++;
          $display("[TB] FAIL b_kind: err=%0b at cycle %0d, required err=%0b", dec_err_b, cyc, qb[0].is_err);
        end else if (!qb[0].is_err && dec_value_b !== qb[0].value[7:0]) begin
          n_errors++;
          $display("[TB] FAIL b_value: dec_value=%0d, required %0d", dec_value_b, qb[0].value[7:0]);
        end
        void'(qb.pop_front());
      end
    end
    while (qb.size() > 0 && qb[0].due < cyc) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL b_missing: no pulse err=%0b at cycle %0d", qb[0].is_err, qb[0].due);
      void'(qb.pop_front());
    end
  end

  // Drives one byte for one cycle and records the pulse it should cause one cycle later
  task automatic send(input bit to_b, input logic [7:0] ch, input int ev, input logic [24:0] val);
    exp_t e;
    @(negedge clk);
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
    if (to_b) begin
      rx_data_b  = ch;
      rx_valid_b = 1'b1;
    end else begin
      rx_data_a  = ch;
      rx_valid_a = 1'b1;
    end
    if (ev != EV_NONE) begin
      e.is_err = (ev == EV_ERR);
      e.value  = val;
      e.due    = cyc + 1;
      if (to_b) qb.push_back(e);
      else      qa.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({dec_valid_a, dec_err_a, busy_a} !== 3'b000 || dec_value_a !== 25'd0) begin
      n_errors++;
      $display("[TB] FAIL reset_a: valid/err/busy=%b value=%0d, required 000 and 0", {dec_valid_a, dec_err_a, busy_a}, dec_value_a);
    end
    n_checks++;
    if ({dec_valid_b, dec_err_b, busy_b} !== 3'b000 || dec_value_b !== 8'd0) begin
      n_errors++;
      $display("[TB] FAIL reset_b: valid/err/busy=%b value=%0d, required 000 and 0", {dec_valid_b, dec_err_b, busy_b}, dec_value_b);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    send(0, "1", EV_NONE, 0);
    send(0, "2", EV_NONE, 0);
    idle(1);
    n_checks++;
    if (busy_a !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL basic_busy: busy=%0b, required 1", busy_a);
    end
    send(0, "3", EV_NONE, 0);
    send(0, 8'h0D, EV_VALID, 25'd123);
    idle(3);
    n_checks++;
    if (dec_value_a !== 25'd123 || busy_a !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL basic_value: value=%0d busy=%0b, required 123 and 0", dec_value_a, busy_a);
    end
  endtask

  task automatic test_back_to_back();
    send(0, "4", EV_NONE, 0);
    send(0, "5", EV_NONE, 0);
    send(0, 8'h0D, EV_VALID, 25'd45);
    send(0, 8'h0A, EV_NONE, 0);
    idle(3);
    n_checks++;
    if (dec_value_a !== 25'd45) begin
      n_errors++;
      $display("[TB] FAIL b2b_value: value=%0d, required 45", dec_value_a);
    end
  endtask

  task automatic test_bad_char();
    send(0, "1", EV_NONE, 0);
    send(0, "x", EV_ERR, 0);
    send(0, "2", EV_NONE, 0);
    send(0, 8'h0D, EV_NONE, 0);
    idle(3);
    n_checks++;
    if (dec_value_a !== 25'd45 || busy_a !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL badchar_hold: value=%0d busy=%0b, required 45 and 0", dec_value_a, busy_a);
    end
  endtask

  task automatic test_max_digits();
    for (int i = 1; i <= 7; i++) send(0, 8'h30 + 8'(i), EV_NONE, 0);
    send(0, "8", EV_ERR, 0);
    send(0, 8'h0D, EV_NONE, 0);
    send(0, "9", EV_NONE, 0);
    send(0, 8'h0D, EV_VALID, 25'd9);
    idle(3);
    n_checks++;
    if (dec_value_a !== 25'd9) begin
      n_errors++;
      $display("[TB] FAIL maxdig_value: value=%0d, required 9", dec_value_a);
    end
  endtask

  task automatic test_space();
    send(0, " ", EV_NONE, 0);
    send(0, "6", EV_NONE, 0);
    send(0, " ", EV_ERR, 0);
    send(0, 8'h0D, EV_NONE, 0);
    send(0, " ", EV_NONE, 0);
    send(0, 8'h0A, EV_NONE, 0);
    idle(3);
    n_checks++;
    if (dec_value_a !== 25'd9 || busy_a !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL space_hold: value=%0d busy=%0b, required 9 and 0", dec_value_a, busy_a);
    end
  endtask

  task automatic test_overflow();
    send(1, "1", EV_NONE, 0);
    send(1, "2", EV_NONE, 0);
    send(1, 8'h0D, EV_VALID, 25'd12);
    send(1, "2", EV_NONE, 0);
    send(1, "5", EV_NONE, 0);
    send(1, "6", EV_ERR, 0);
    send(1, 8'h0D, EV_NONE, 0);
    idle(2);
    n_checks++;
    if (dec_value_b !== 8'd12) begin
      n_errors++;
      $display("[TB] FAIL ovf_hold: value=%0d, required 12", dec_value_b);
    end
    send(1, "2", EV_NONE, 0);
    send(1, "5", EV_NONE, 0);
    send(1, "5", EV_NONE, 0);
    send(1, 8'h0D, EV_VALID, 25'd255);
    for (int i = 0; i < 3; i++) send(1, "0", EV_NONE, 0);
    send(1, "7", EV_ERR, 0);
    send(1, 8'h0D, EV_NONE, 0);
    idle(3);
    n_checks++;
    if (dec_value_b !== 8'd255) begin
      n_errors++;
      $display("[TB] FAIL ovf_max: value=%0d, required 255", dec_value_b);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    logic        busy_exp;
    logic [24:0] val_exp;
    send(0, "5", EV_NONE, 0);
`ifdef DEC_PARSER_TIMEOUT_EN
    e.is_err = 1'b1;
    e.value  = 0;
    e.due    = cyc + 1 + 100;
    qa.push_back(e);
    busy_exp = 1'b0;
    val_exp  = 25'd7;
`else
    e.is_err = 1'b0;
    busy_exp = 1'b1;
    val_exp  = 25'd57;
`endif
    idle(110);
    n_checks++;
    if (busy_a !== busy_exp) begin
      n_errors++;
      $display("[TB] FAIL timeout_busy: busy=%0b, required %0b", busy_a, busy_exp);
    end
    send(0, "7", EV_NONE, 0);
    send(0, 8'h0D, EV_VALID, val_exp);
    idle(3);
    n_checks++;
    if (dec_value_a !== val_exp) begin
      n_errors++;
      $display("[TB] FAIL timeout_value: value=%0d, required %0d", dec_value_a, val_exp);
    end
  endtask

  task automatic test_reset_midline();
    send(0, "1", EV_NONE, 0);
    send(0, "2", EV_NONE, 0);
    @(negedge clk);
    rx_valid_a = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b0 || dec_value_a !== 25'd0) begin
      n_errors++;
      $display("[TB] FAIL rstmid_clear: busy=%0b value=%0d, required 0 and 0", busy_a, dec_value_a);
    end
    rst = 1'b0;
    send(0, "3", EV_NONE, 0);
    send(0, 8'h0D, EV_VALID, 25'd3);
    idle(3);
    n_checks++;
    if (dec_value_a !== 25'd3) begin
      n_errors++;
      $display("[TB] FAIL rstmid_value: value=%0d, required 3", dec_value_a);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_bad_char();
    test_max_digits();
    test_space();
    test_overflow();
    test_timeout();
    test_reset_midline();
    idle(3);
    n_checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL drain: pending a=%0d b=%0d, required 0 and 0", qa.size(), qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
